// File: rtl/cgra_io_stream_ctrl_if.sv
// Host/array signal bundle for the CGRA IO stream controller.
// slave = controller side, master = host plus array IO PEs.
interface cgra_io_stream_ctrl_if #(
    parameter int SYS_DWIDTH = 32,
    parameter int AW         = 4
);
    logic                    In_Valid;
    logic                    In_Ready;
    logic [2*SYS_DWIDTH-1:0] In_Data;
    logic                    Start;
    logic [AW:0]             Run_Len;
    logic                    Out_Valid;
    logic                    Out_Ready;
    logic [2*SYS_DWIDTH-1:0] Out_Data;
    logic                    Done;
    logic [SYS_DWIDTH-1:0]   Data0_Load;
    logic [SYS_DWIDTH-1:0]   Data1_Load;
    logic [SYS_DWIDTH-1:0]   Data0_Store;
    logic [SYS_DWIDTH-1:0]   Data1_Store;
    logic                    PE_Array_Busy;

    modport slave (
        input  In_Valid, In_Data, Start, Run_Len, Out_Ready, Data0_Store, Data1_Store,
        output In_Ready, Out_Valid, Out_Data, Done, Data0_Load, Data1_Load, PE_Array_Busy
    );

    modport master (
        output In_Valid, In_Data, Start, Run_Len, Out_Ready, Data0_Store, Data1_Store,
        input  In_Ready, Out_Valid, Out_Data, Done, Data0_Load, Data1_Load, PE_Array_Busy
    );
endinterface

// File: rtl/cgra_io_stream_ctrl.sv
// Buffers host words, feeds them to the IO PE load ports for one run, captures the
// store ports CAP_LAT cycles later and drains the results to the host on valid/ready.
module cgra_io_stream_ctrl #(
    parameter int SYS_DWIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int CAP_LAT    = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    cgra_io_stream_ctrl_if.slave io
);
    localparam int DW = 2 * SYS_DWIDTH;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] CAP_C   = (AW+1)'(CAP_LAT);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [AW:0]           fill_cnt_q, fill_cnt_d;
    logic [AW:0]           len_q, len_d;
    logic [AW:0]           run_cnt_q, run_cnt_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [SYS_DWIDTH-1:0] load0_q, load0_d, load1_q, load1_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [DW-1:0] in_mem_q  [DEPTH];
    logic [DW-1:0] res_mem_q [DEPTH];

    logic          in_ready, out_vld;
    logic [DW-1:0] out_dat;
    logic          in_hs, out_hs, start_ok, cap_en, last_cap, last_rd;
    logic [AW:0]   cap_idx, nidx;
    logic          load_en;
    logic [DW-1:0] load_word;

    assign in_hs    = io.In_Valid & in_ready;
    assign out_hs   = out_vld & io.Out_Ready;
    assign start_ok = io.Start && (io.Run_Len != '0) && (io.Run_Len <= DEPTH_C);
    assign cap_en   = (state_q == RUN) && (run_cnt_q >= CAP_C);
    assign cap_idx  = run_cnt_q - CAP_C;
    assign last_cap = (state_q == RUN) && (run_cnt_q == len_q + CAP_C - 1'b1);
    assign last_rd  = out_hs && (rd_ptr_q == len_q - 1'b1);

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (last_cap) state_d = DRAIN;
            DRAIN:   if (last_rd)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE) && (fill_cnt_q != DEPTH_C);
        out_vld  = (state_q == DRAIN);
        out_dat  = out_vld ? res_mem_q[rd_ptr_q[AW-1:0]] : '0;
    end

    always_comb begin
        fill_cnt_d = fill_cnt_q;
        len_d      = len_q;
        run_cnt_d  = run_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        nidx       = '0;
        load_en    = 1'b0;
        load_word  = '0;

        if (in_hs)   fill_cnt_d = fill_cnt_q + 1'b1;
        if (last_rd) fill_cnt_d = '0;

        case (state_q)
            IDLE: if (start_ok) begin
                len_d     = io.Run_Len;
                run_cnt_d = '0;
                rd_ptr_d  = '0;
                load_en   = 1'b1;
            end
            RUN: begin
                run_cnt_d = run_cnt_q + 1'b1;
                nidx      = run_cnt_q + 1'b1;
                load_en   = (nidx < len_q);
            end
            DRAIN: if (out_hs) rd_ptr_d = rd_ptr_q + 1'b1;
            default: ;
        endcase

        // A word accepted in the Start cycle is entry 0 of the run, so bypass the buffer.
        if (load_en) begin
            if (in_hs && (nidx == fill_cnt_q)) load_word = io.In_Data;
            else if (nidx < fill_cnt_q)        load_word = in_mem_q[nidx[AW-1:0]];
        end

        load0_d = load_word[SYS_DWIDTH-1:0];
        load1_d = load_word[DW-1:SYS_DWIDTH];
        busy_d  = (state_d == RUN);
        done_d  = last_rd;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fill_cnt_q <= '0;
            len_q      <= '0;
            run_cnt_q  <= '0;
            rd_ptr_q   <= '0;
            load0_q    <= '0;
            load1_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            fill_cnt_q <= fill_cnt_d;
            len_q      <= len_d;
            run_cnt_q  <= run_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            load0_q    <= load0_d;
            load1_q    <= load1_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset && in_hs)  in_mem_q[fill_cnt_q[AW-1:0]] <= io.In_Data;
        if (!Reset && cap_en) res_mem_q[cap_idx[AW-1:0]]   <= {io.Data1_Store, io.Data0_Store};
    end

    assign io.In_Ready      = in_ready;
    assign io.Out_Valid     = out_vld;
    assign io.Out_Data      = out_dat;
    assign io.Done          = done_q;
    assign io.Data0_Load    = load0_q;
    assign io.Data1_Load    = load1_q;
    assign io.PE_Array_Busy = busy_q;
endmodule

// File: tb/tb_cgra_io_stream_ctrl.sv
// Directed bench for cgra_io_stream_ctrl; the array is mocked as store = load + 1, 2 cycles later.
module tb_cgra_io_stream_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [63:0] load_exp [16];
    logic [63:0] p1, p2;

    always #5 clk = ~clk;

    cgra_io_stream_ctrl_if #(.SYS_DWIDTH(32), .AW(4)) io ();

    cgra_io_stream_ctrl #(.SYS_DWIDTH(32), .DEPTH(16), .AW(4), .CAP_LAT(2)) dut (
        .Clk   (clk),
        .Reset (rst),
        .io    (io)
    );

    always @(posedge clk) begin
        p1 <= {io.Data1_Load + 32'd1, io.Data0_Load + 32'd1};
        p2 <= p1;
    end
    assign io.Data0_Store = p2[31:0];
    assign io.Data1_Store = p2[63:32];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] d);
        io.In_Valid = 1'b1;
        io.In_Data  = d;
        tick();
        io.In_Valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(io.In_Ready), 64'd1);
        chk({tag, "_busy"},     64'(io.PE_Array_Busy), 64'd0);
        chk({tag, "_out_vld"},  64'(io.Out_Valid), 64'd0);
        chk({tag, "_done"},     64'(io.Done), 64'd0);
        chk({tag, "_load"},     {io.Data1_Load, io.Data0_Load}, 64'd0);
    endtask

    // Start a run of length len (optionally pushing a word in the Start cycle),
    // check loads and Busy length, then drain and check results and Done.
    task automatic do_run(input string tag, input int len, input bit toggle,
                          input bit push_too, input logic [63:0] push_dat);
        int n;
        int idx;
        int cyc;
        logic [63:0] e;
        io.Start    = 1'b1;
        io.Run_Len  = 5'(len);
        io.In_Valid = push_too;
        io.In_Data  = push_dat;
        tick();
        io.Start    = 1'b0;
        io.In_Valid = 1'b0;
        chk({tag, "_in_ready_run"}, 64'(io.In_Ready), 64'd0);
        n = 0;
        while (io.PE_Array_Busy === 1'b1 && n < 100) begin
            if (n < len) chk($sformatf("%s_load%0d", tag, n), {io.Data1_Load, io.Data0_Load}, load_exp[n]);
            else         chk($sformatf("%s_load_tail%0d", tag, n), {io.Data1_Load, io.Data0_Load}, 64'd0);
            tick();
            n++;
        end
        chk({tag, "_busy_cycles"}, 64'(n), 64'(len + 2));
        idx = 0;
        cyc = 0;
        while (idx < len && cyc < 200) begin
            io.Out_Ready = toggle ? cyc[0] : 1'b1;
            #1;
            e = {load_exp[idx][63:32] + 32'd1, load_exp[idx][31:0] + 32'd1};
            chk($sformatf("%s_out_vld%0d", tag, idx), 64'(io.Out_Valid), 64'd1);
            chk($sformatf("%s_out%0d", tag, idx), io.Out_Data, e);
            if (idx < len - 1 || io.Out_Ready == 1'b0)
                chk($sformatf("%s_done_early%0d", tag, idx), 64'(io.Done), 64'd0);
            if (io.Out_Ready) idx++;
            tick();
            cyc++;
        end
        io.Out_Ready = 1'b0;
        chk({tag, "_drained"}, 64'(idx), 64'(len));
        chk({tag, "_done"}, 64'(io.Done), 64'd1);
        chk({tag, "_out_vld_end"}, 64'(io.Out_Valid), 64'd0);
        chk({tag, "_in_ready_end"}, 64'(io.In_Ready), 64'd1);
        tick();
        chk({tag, "_done_pulse"}, 64'(io.Done), 64'd0);
    endtask

    initial begin
        io.In_Valid  = 1'b0;
        io.In_Data   = '0;
        io.Start     = 1'b0;
        io.Run_Len   = '0;
        io.Out_Ready = 1'b0;
        p1 = '0;
        p2 = '0;

        // 1: reset
        rst = 1'b1;
        tick();
        tick();
        check_idle_outputs("reset");
        chk("reset_out_data", io.Out_Data, 64'd0);
        rst = 1'b0;
        tick();
        check_idle_outputs("post_reset");

        // 2: basic run of 4
        for (int i = 0; i < 4; i++) begin
            load_exp[i] = {32'(i + 'h100), 32'(i)};
            push(load_exp[i]);
        end
        do_run("basic", 4, 1'b0, 1'b0, 64'd0);

        // 3: full buffer, rejected 17th word, run of 16 under backpressure
        for (int i = 0; i < 16; i++) begin
            load_exp[i] = {32'(i + 'h200), 32'(3 * i + 7)};
            push(load_exp[i]);
        end
        chk("full_in_ready", 64'(io.In_Ready), 64'd0);
        push(64'hDEAD_BEEF_CAFE_F00D);
        chk("full_in_ready_after17", 64'(io.In_Ready), 64'd0);
        do_run("full", 16, 1'b1, 1'b0, 64'd0);

        // 4: short fill, third load reads empty entry
        load_exp[0] = 64'h0000_0AAA_0000_0555;
        load_exp[1] = 64'h0000_0BBB_0000_0666;
        load_exp[2] = 64'd0;
        push(load_exp[0]);
        push(load_exp[1]);
        do_run("short", 3, 1'b0, 1'b0, 64'd0);

        // 5: illegal Run_Len ignored; Start with same-cycle push
        io.Start   = 1'b1;
        io.Run_Len = 5'd0;
        tick();
        io.Run_Len = 5'd17;
        tick();
        io.Start = 1'b0;
        tick();
        check_idle_outputs("bad_len");
        load_exp[0] = 64'h1234_5678_9ABC_DEF0;
        do_run("same_cycle", 1, 1'b0, 1'b1, load_exp[0]);

        // 6: reset mid-run at k=2, then a fresh run
        for (int i = 0; i < 4; i++) push({32'(i + 'h300), 32'(i + 'h40)});
        io.Start   = 1'b1;
        io.Run_Len = 5'd4;
        tick();
        io.Start = 1'b0;
        tick();
        tick();
        chk("midrun_busy_before", 64'(io.PE_Array_Busy), 64'd1);
        chk("midrun_load_k2", 64'(io.Data0_Load), 64'h42);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("midrun_reset");
        tick();
        check_idle_outputs("midrun_idle");
        load_exp[0] = 64'h0000_0777_0000_0011;
        load_exp[1] = 64'h0000_0888_0000_0022;
        push(load_exp[0]);
        push(load_exp[1]);
        do_run("fresh", 2, 1'b1, 1'b0, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
